// File: rtl/s420_ctrl_pkg.sv
// Shared types and constants for the s420 interval sequencer.
// Holds the FSM state encoding, default widths and the saturating-increment helper.
package s420_ctrl_pkg;

   localparam int unsigned CW_DEF = 17;
   localparam int unsigned LW_DEF = 8;
   localparam int unsigned HW_DEF = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      RUN    = 3'd2,
      SETTLE = 3'd3,
      REPORT = 3'd4
   } state_e;

   // Increment that sticks at max_val instead of wrapping
   function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
      return (val >= max_val) ? val : val + 32'd1;
   endfunction

endpackage

// File: rtl/s420_interval_ctrl_if.sv
// Host request/result handshakes plus the s420 datapath hookup (C word, P_0 enable, Z).
// The slave modport is the controller's view; master is the host/datapath side.
interface s420_interval_ctrl_if #(
   parameter int unsigned CW = s420_ctrl_pkg::CW_DEF,
   parameter int unsigned LW = s420_ctrl_pkg::LW_DEF,
   parameter int unsigned HW = s420_ctrl_pkg::HW_DEF
) ();

   logic          REQ_VALID;
   logic          REQ_READY;
   logic [CW-1:0] REQ_CW;
   logic [LW-1:0] REQ_LEN;
   logic          ABORT;
   logic [CW-1:0] C_OUT;
   logic          EN_OUT;
   logic          Z_IN;
   logic          DONE_VALID;
   logic          DONE_READY;
   logic [HW-1:0] HIT_CNT;
   logic          ABORTED;
   logic          BUSY;

   modport slave (
      input  REQ_VALID, REQ_CW, REQ_LEN, ABORT, Z_IN, DONE_READY,
      output REQ_READY, C_OUT, EN_OUT, DONE_VALID, HIT_CNT, ABORTED, BUSY
   );

   modport master (
      output REQ_VALID, REQ_CW, REQ_LEN, ABORT, Z_IN, DONE_READY,
      input  REQ_READY, C_OUT, EN_OUT, DONE_VALID, HIT_CNT, ABORTED, BUSY
   );

endinterface

// File: rtl/s420_sat_counter.sv
// W-bit hit counter with synchronous clear and saturating increment.
module s420_sat_counter
   import s420_ctrl_pkg::*;
#(
   parameter int unsigned W = HW_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   localparam logic [W-1:0] MAX_VAL = '1;

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = W'(sat_inc(32'(cnt_q), 32'(MAX_VAL)));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/s420_interval_ctrl.sv
// Sequencer for one s420 counter/comparator: applies a C word, drives P_0 for a
// requested number of cycles, counts Z hits and returns the count over a handshake.
module s420_interval_ctrl
   import s420_ctrl_pkg::*;
#(
   parameter int unsigned CW = CW_DEF,
   parameter int unsigned LW = LW_DEF,
   parameter int unsigned HW = HW_DEF
) (
   input logic                CK,
   input logic                RST,
   s420_interval_ctrl_if.slave bus
);

   state_e        state_q, state_d;
   logic [LW-1:0] len_q, len_d;
   logic [CW-1:0] c_q, c_d;
   logic          en_q, en_d;
   logic          req_ready_q, req_ready_d;
   logic          done_valid_q, done_valid_d;
   logic          aborted_q, aborted_d;
   logic          busy_q, busy_d;
   logic          accept_c;
   logic          hit_clr_c, hit_inc_c;
   logic          abortable_c;

   assign accept_c    = (state_q == IDLE) && req_ready_q && bus.REQ_VALID;
   assign abortable_c = (state_q == LOAD) || (state_q == RUN) || (state_q == SETTLE);

   // State and registered-output flops
   always_ff @(posedge CK) begin
      if (RST) begin
         state_q      <= IDLE;
         len_q        <= '0;
         c_q          <= '0;
         en_q         <= 1'b0;
         req_ready_q  <= 1'b1;
         done_valid_q <= 1'b0;
         aborted_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         c_q          <= c_d;
         en_q         <= en_d;
         req_ready_q  <= req_ready_d;
         done_valid_q <= done_valid_d;
         aborted_q    <= aborted_d;
         busy_q       <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept_c) state_d = LOAD;
         LOAD: begin
            if (bus.ABORT)          state_d = REPORT;
            else if (len_q != '0)   state_d = RUN;
            else                    state_d = SETTLE;
         end
         RUN: begin
            if (bus.ABORT)               state_d = REPORT;
            else if (len_q == LW'(1))    state_d = SETTLE;
         end
         SETTLE:  state_d = REPORT;
         REPORT:  if (bus.DONE_READY) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Flag outputs are a look-ahead of the next state so they line up with it
   always_comb begin
      c_d          = c_q;
      len_d        = len_q;
      aborted_d    = aborted_q;
      hit_clr_c    = 1'b0;
      hit_inc_c    = 1'b0;
      req_ready_d  = (state_d == IDLE);
      en_d         = (state_d == RUN);
      done_valid_d = (state_d == REPORT);
      busy_d       = (state_d != IDLE);

      if (accept_c) begin
         c_d       = bus.REQ_CW;
         len_d     = bus.REQ_LEN;
         aborted_d = 1'b0;
         hit_clr_c = 1'b1;
      end
      if (state_q == RUN) begin
         len_d = len_q - LW'(1);
      end
      if ((state_q == RUN) || (state_q == SETTLE)) begin
         hit_inc_c = bus.Z_IN;
      end
      if (abortable_c && bus.ABORT) begin
         aborted_d = 1'b1;
      end
   end

   s420_sat_counter #(.W(HW)) u_hit_cnt (
      .clk   (CK),
      .rst   (RST),
      .clr_i (hit_clr_c),
      .inc_i (hit_inc_c),
      .cnt_o (bus.HIT_CNT)
   );

   assign bus.C_OUT      = c_q;
   assign bus.EN_OUT     = en_q;
   assign bus.REQ_READY  = req_ready_q;
   assign bus.DONE_VALID = done_valid_q;
   assign bus.ABORTED    = aborted_q;
   assign bus.BUSY       = busy_q;

endmodule

// File: tb/tb_s420_interval_ctrl.sv
// Bench for s420_interval_ctrl: directed and randomized jobs checked cycle by cycle
// against timing and hit-count rules derived from the job parameters.
module tb_s420_interval_ctrl;

   localparam int unsigned CW = 17;
   localparam int unsigned LW = 8;
   localparam int unsigned HW = 8;

   logic ck = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;

   s420_interval_ctrl_if #(.CW(CW), .LW(LW), .HW(HW)) bus ();

   s420_interval_ctrl #(.CW(CW), .LW(LW), .HW(HW)) dut (
      .CK  (ck),
      .RST (rst),
      .bus (bus)
   );

   always #5 ck = ~ck;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_req_ready"},  32'(bus.REQ_READY),  32'd1);
      check({tag, "_c_out"},      32'(bus.C_OUT),      32'd0);
      check({tag, "_en_out"},     32'(bus.EN_OUT),     32'd0);
      check({tag, "_done_valid"}, 32'(bus.DONE_VALID), 32'd0);
      check({tag, "_hit_cnt"},    32'(bus.HIT_CNT),    32'd0);
      check({tag, "_aborted"},    32'(bus.ABORTED),    32'd0);
      check({tag, "_busy"},       32'(bus.BUSY),       32'd0);
   endtask

   // abort_k: 0 = none, k = abort raised on enable cycle k, len+1 = during SETTLE.
   // zmode: 0 all low, 1 all high, 2 random, 3 bit c of zmask for cycle c.
   task automatic run_job(input logic [CW-1:0] cw, input int len, input int abort_k,
                          input int zmode, input logic [31:0] zmask, input int hold);
      int a, done_c, en_last, last_sample, sum, exp_hit;
      bit z, in_win;
      a           = (abort_k > 0) ? abort_k + 1 : 0;
      done_c      = (a > 0) ? a + 1 : len + 3;
      en_last     = (a > 0 && a < len + 1) ? a : len + 1;
      last_sample = (a > 0) ? a : len + 2;
      sum         = 0;

      @(negedge ck);
      check("accept_ready", 32'(bus.REQ_READY), 32'd1);
      check("accept_busy",  32'(bus.BUSY),      32'd0);
      bus.REQ_VALID  = 1'b1;
      bus.REQ_CW     = cw;
      bus.REQ_LEN    = LW'(len);
      bus.ABORT      = 1'($urandom);
      bus.DONE_READY = 1'b0;
      bus.Z_IN       = 1'($urandom);

      for (int c = 1; c < done_c; c++) begin
         @(negedge ck);
         check("en_out",     32'(bus.EN_OUT),     32'((c >= 2) && (c <= en_last)));
         check("busy",       32'(bus.BUSY),       32'd1);
         check("req_ready",  32'(bus.REQ_READY),  32'd0);
         check("done_early", 32'(bus.DONE_VALID), 32'd0);
         check("c_out",      32'(bus.C_OUT),      32'(cw));
         bus.REQ_VALID = 1'($urandom);
         bus.REQ_CW    = CW'($urandom);
         bus.REQ_LEN   = LW'($urandom);
         in_win = (c >= 2) && (c <= last_sample);
         case (zmode)
            0:       z = in_win ? 1'b0 : 1'($urandom);
            1:       z = in_win ? 1'b1 : 1'($urandom);
            3:       z = (c < 32) ? zmask[5'(c)] : 1'b0;
            default: z = 1'($urandom);
         endcase
         bus.Z_IN  = z;
         if (in_win && z) sum++;
         bus.ABORT = (c == a);
      end

      exp_hit = (sum > 255) ? 255 : sum;
      for (int h = 0; h <= hold; h++) begin
         @(negedge ck);
         check("done_valid", 32'(bus.DONE_VALID), 32'd1);
         check("hit_cnt",    32'(bus.HIT_CNT),    32'(exp_hit));
         check("aborted",    32'(bus.ABORTED),    32'(a > 0));
         check("report_en",  32'(bus.EN_OUT),     32'd0);
         check("report_rdy", 32'(bus.REQ_READY),  32'd0);
         bus.Z_IN       = 1'($urandom);
         bus.ABORT      = 1'($urandom);
         bus.DONE_READY = (h == hold);
         bus.REQ_VALID  = (h == hold) ? 1'b1 : 1'($urandom);
      end

      // Request offered alongside DONE_READY must not be taken at that edge
      @(negedge ck);
      check("release_done",  32'(bus.DONE_VALID), 32'd0);
      check("release_ready", 32'(bus.REQ_READY),  32'd1);
      check("release_busy",  32'(bus.BUSY),       32'd0);
      check("release_c_out", 32'(bus.C_OUT),      32'(cw));
      bus.REQ_VALID  = 1'b0;
      bus.DONE_READY = 1'b0;
      bus.ABORT      = 1'b0;
   endtask

   initial begin
      int len, ak;
      rst            = 1'b1;
      bus.REQ_VALID  = 1'b0;
      bus.REQ_CW     = '0;
      bus.REQ_LEN    = '0;
      bus.ABORT      = 1'b0;
      bus.Z_IN       = 1'b0;
      bus.DONE_READY = 1'b0;
      repeat (3) @(posedge ck);
      @(negedge ck);
      check_reset_state("reset");
      rst = 1'b0;

      run_job(17'h00010, 5, 0, 0, 32'h0, 0);
      run_job(17'h1ABCD, 4, 0, 3, 32'h68, 2);
      run_job(17'h0F0F0, 0, 0, 1, 32'h0, 1);
      run_job(17'h12345, 0, 0, 0, 32'h0, 0);
      run_job(17'h00FFF, 255, 0, 1, 32'h0, 1);
      run_job(17'h0A5A5, 10, 3, 1, 32'h0, 0);
      run_job(17'h05555, 6, 7, 1, 32'h0, 0);

      // Reset in the middle of an enable run
      @(negedge ck);
      bus.REQ_VALID = 1'b1;
      bus.REQ_CW    = 17'h1F00F;
      bus.REQ_LEN   = 8'd10;
      bus.Z_IN      = 1'b1;
      @(negedge ck);
      bus.REQ_VALID = 1'b0;
      repeat (3) @(negedge ck);
      check("midrun_en",  32'(bus.EN_OUT),  32'd1);
      check("midrun_hit", 32'(bus.HIT_CNT), 32'd2);
      rst = 1'b1;
      @(negedge ck);
      check_reset_state("midrun_rst");
      rst       = 1'b0;
      bus.Z_IN  = 1'b0;
      @(negedge ck);
      check_reset_state("post_rst");

      run_job(17'h00123, 3, 0, 2, 32'h0, 4);

      for (int j = 0; j < 10; j++) begin
         len = $urandom_range(0, 20);
         ak  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, len + 1) : 0;
         run_job(CW'($urandom), len, ak, 2, 32'h0, $urandom_range(0, 3));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/s420_interval_ctrl.md
Name: s420_interval_ctrl

Overview:
- Sequencer for the s420 counter/comparator datapath.
- Accepts a compare-word and enable-length request over a valid/ready handshake, drives the datapath's C word and count-enable (P_0), and counts comparator hits (Z).
- Reports the hit count over a second valid/ready handshake.
- Sits between a host requester and one s420 instance. It is the only driver of that instance's C_x and P_0 inputs.

Parameters:
- CW, 17, compare-word width (C_0..C_16).
- LW, 8, run-length width (enable-cycle count).
- HW, 8, hit-counter width.

Ports:
- CK, input, 1, clock (rising edge).
- RST, input, 1, synchronous active-high reset.
- REQ_VALID, input, 1, request offered.
- REQ_READY, output, 1, controller can accept a request.
- REQ_CW, input, CW, compare word to apply.
- REQ_LEN, input, LW, number of enable cycles; 0 means no enable cycles.
- ABORT, input, 1, terminate the current run early.
- C_OUT, output, CW, compare word to datapath C inputs.
- EN_OUT, output, 1, count enable to datapath P_0.
- Z_IN, input, 1, datapath comparator output.
- DONE_VALID, output, 1, result available.
- DONE_READY, input, 1, result consumed.
- HIT_CNT, output, HW, number of Z hits in the run.
- ABORTED, output, 1, result came from an aborted run.
- BUSY, output, 1, state is not IDLE.

Behaviour:
- Reset: RST sampled high at a CK edge forces, from the next cycle, state IDLE, REQ_READY=1 and all other outputs 0 (C_OUT=0, EN_OUT=0, DONE_VALID=0, HIT_CNT=0, ABORTED=0, BUSY=0). Internal length and hit counters are also cleared. RST overrides every other input, including mid-run; there is no drain.
- States: IDLE, LOAD, RUN, SETTLE, REPORT. All outputs are registered.
- IDLE:
  - REQ_READY=1.
  - On REQ_VALID & REQ_READY: latch REQ_CW into C_OUT, latch REQ_LEN into a remaining-length counter, clear HIT_CNT and ABORTED, go to LOAD.
- LOAD:
  - Exactly one cycle; EN_OUT=0, so the comparator sees the new C word.
  - Go to RUN if length != 0, else go to SETTLE.
- RUN:
  - EN_OUT=1 every cycle.
  - Each cycle: if Z_IN=1, HIT_CNT increments, saturating at 2^HW-1. Remaining length decrements.
  - When remaining reaches 1 at a clock edge (the last enable cycle), go to SETTLE.
  - Result: exactly REQ_LEN consecutive EN_OUT cycles.
- SETTLE:
  - One cycle; EN_OUT=0.
  - Sample Z_IN once more; a hit increments HIT_CNT with the same saturation. This captures the state after the final enable.
  - Go to REPORT.
- REPORT:
  - DONE_VALID=1. HIT_CNT and ABORTED are held stable while DONE_VALID=1 and DONE_READY=0.
  - On DONE_READY: go to IDLE, DONE_VALID drops next cycle.
  - C_OUT holds its last value until the next accept.
- ABORT:
  - Sampled in LOAD, RUN or SETTLE: set ABORTED=1, EN_OUT=0 from the next cycle, skip directly to REPORT.
  - The Z sample of the abort cycle is still counted.
  - Ignored in IDLE and REPORT.
- REQ_READY is 0 in every state except IDLE; there is no request queuing. REQ_VALID during busy states is ignored, and the requester must hold it.
- BUSY = (state != IDLE).
- Latency: accept to DONE_VALID = REQ_LEN + 3 cycles (LOAD + RUN*LEN + SETTLE, then REPORT registered).
- Simultaneous DONE_READY and a new REQ_VALID: the request is accepted only in the following IDLE cycle. Minimum 1 idle cycle between jobs.

Decomposition:
- Package s420_ctrl_pkg: state enum (IDLE, LOAD, RUN, SETTLE, REPORT), CW/LW/HW default constants, saturating-increment function.
- One sub-module, s420_sat_counter (HW-bit, clear/inc, saturating), used for HIT_CNT.
- The length counter stays inline in the FSM.

Test Plan:
- Reset then REQ_CW=17'h00010, REQ_LEN=5, Z_IN tied 0 -> EN_OUT high exactly 5 cycles starting 2 cycles after accept; DONE_VALID at accept+8; HIT_CNT=0; ABORTED=0.
- REQ_LEN=4, Z_IN=1 on RUN cycles 2 and 4 plus the SETTLE cycle -> HIT_CNT=3.
- REQ_LEN=0 -> no EN_OUT pulse; DONE_VALID at accept+3; HIT_CNT counts only the SETTLE Z sample.
- REQ_LEN=255, Z_IN=1 constantly, HW=8 -> HIT_CNT saturates at 255, no wrap.
- ABORT on RUN cycle 3 of LEN=10 -> EN_OUT low next cycle; REPORT with ABORTED=1; HIT_CNT includes the abort-cycle sample.
- RST asserted mid-RUN, then DONE_READY held 0 in REPORT for 4 cycles -> after RST all outputs 0 and REQ_READY=1 next cycle; in REPORT, HIT_CNT and DONE_VALID are held stable until DONE_READY.
